// File: rtl/mem_write_checker.sv
// mem_write_checker: watches a data-memory write bus against an ordered table
// of expected (address, data) writes and reports pass/fail, a cause code,
// match progress and elapsed RUN cycles.
//
// Handshake note: there is no valid/ready pair here. exp_wr is a one-cycle
// push strobe honoured only in IDLE, start is a one-cycle strobe honoured in
// IDLE/PASS/FAIL, memwrite qualifies adr/writedata on the sampling edge, and
// clear overrides everything else on the edge it is seen.
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    parameter int CYC_W   = 16,
    parameter int STRICT  = 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             exp_wr,
    input  logic [WIDTH-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             start,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] exp_cnt,
    output logic [CYC_W-1:0] cycles,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] F_NONE = 2'd0;
    localparam logic [1:0] F_ADDR = 2'd1;
    localparam logic [1:0] F_DATA = 2'd2;
    localparam logic [1:0] F_TMO  = 2'd3;

    localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_match_cnt, w_match_nx;
    logic [CNT_W-1:0] r_exp_cnt, w_exp_cnt_nx;
    logic [CYC_W-1:0] r_cycles, w_cycles_nx;
    logic [1:0]       r_fail_code, w_code_nx;
    logic             r_ovf, w_ovf_nx;
    logic             w_push;

    logic [WIDTH-1:0] r_tab_addr [DEPTH];
    logic [WIDTH-1:0] r_tab_data [DEPTH];

    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [CNT_W-1:0] w_match_inc;
    logic             w_adr_eq;
    logic             w_data_eq;

    // Entries are only addressed while the count is below DEPTH, so the
    // truncated index is always in range when it is actually used.
    assign w_wr_idx    = r_exp_cnt[IDX_W-1:0];
    assign w_rd_idx    = r_match_cnt[IDX_W-1:0];
    assign w_match_inc = r_match_cnt + CNT_W'(1);

    // Case equality so an X/Z on the bus never counts as a match.
    assign w_adr_eq  = (adr === r_tab_addr[w_rd_idx]);
    assign w_data_eq = (writedata === r_tab_data[w_rd_idx]);

    // Expected-write table storage; pushes land at the current fill level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_addr[i] <= '0;
                r_tab_data[i] <= '0;
            end
        end else if (w_push) begin
            r_tab_addr[w_wr_idx] <= exp_addr;
            r_tab_data[w_wr_idx] <= exp_data;
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_match_cnt <= '0;
            r_exp_cnt   <= '0;
            r_cycles    <= '0;
            r_fail_code <= F_NONE;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_match_cnt <= w_match_nx;
            r_exp_cnt   <= w_exp_cnt_nx;
            r_cycles    <= w_cycles_nx;
            r_fail_code <= w_code_nx;
            r_ovf       <= w_ovf_nx;
        end
    end

    // Next-state and next-status decode; clear outranks every other request.
    always_comb begin
        w_state_nx   = r_state;
        w_match_nx   = r_match_cnt;
        w_exp_cnt_nx = r_exp_cnt;
        w_cycles_nx  = r_cycles;
        w_code_nx    = r_fail_code;
        w_ovf_nx     = r_ovf;
        w_push       = 1'b0;

        if (clear) begin
            w_state_nx   = S_IDLE;
            w_match_nx   = '0;
            w_exp_cnt_nx = '0;
            w_cycles_nx  = '0;
            w_code_nx    = F_NONE;
            w_ovf_nx     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (exp_wr) begin
                        if (r_exp_cnt < CNT_W'(DEPTH)) begin
                            w_push       = 1'b1;
                            w_exp_cnt_nx = r_exp_cnt + CNT_W'(1);
                        end else begin
                            w_ovf_nx = 1'b1;
                        end
                    end
                    // A push on the same edge counts toward the table size.
                    if (start) begin
                        w_match_nx  = '0;
                        w_cycles_nx = '0;
                        w_code_nx   = F_NONE;
                        w_state_nx  = (w_exp_cnt_nx == '0) ? S_PASS : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cycles != '1) begin
                        w_cycles_nx = r_cycles + CYC_W'(1);
                    end
                    if (memwrite) begin
                        if (w_adr_eq) begin
                            if (w_data_eq) begin
                                w_match_nx = w_match_inc;
                                if (w_match_inc == r_exp_cnt) begin
                                    w_state_nx = S_PASS;
                                end
                            end else begin
                                w_state_nx = S_FAIL;
                                w_code_nx  = F_DATA;
                            end
                        end else if (STRICT != 0) begin
                            w_state_nx = S_FAIL;
                            w_code_nx  = F_ADDR;
                        end
                    end
                    // Timeout only fires if the write on this edge decided nothing.
                    if ((w_state_nx == S_RUN) && (r_cycles == TMO_LAST)) begin
                        w_state_nx = S_FAIL;
                        w_code_nx  = F_TMO;
                    end
                end
                S_PASS, S_FAIL: begin
                    if (start) begin
                        w_match_nx  = '0;
                        w_cycles_nx = '0;
                        w_code_nx   = F_NONE;
                        w_state_nx  = (r_exp_cnt == '0) ? S_PASS : S_RUN;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_PASS) || (r_state == S_FAIL);
    assign pass      = (r_state == S_PASS);
    assign fail_code = r_fail_code;
    assign match_cnt = r_match_cnt;
    assign exp_cnt   = r_exp_cnt;
    assign cycles    = r_cycles;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a table of directed single-edge vectors plus
// hand-written sequences for timeout, STRICT=0 and asynchronous reset.
module tb_mem_write_checker;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          clear, exp_wr, start, memwrite;
    logic [W-1:0]  exp_addr, exp_data, adr, writedata;

    logic          busy_s, done_s, pass_s, ovf_s;
    logic [1:0]    code_s, dbg_s;
    logic [2:0]    m_s, e_s;
    logic [CW-1:0] cyc_s;

    logic          busy_l, done_l, pass_l, ovf_l;
    logic [1:0]    code_l, dbg_l;
    logic [2:0]    m_l, e_l;
    logic [CW-1:0] cyc_l;

    int n_checks;
    int n_fail;

    mem_write_checker #(.WIDTH(W), .DEPTH(4), .TIMEOUT(20), .CYC_W(CW), .STRICT(1)) u_s (
        .clk(clk), .reset(reset), .clear(clear), .exp_wr(exp_wr),
        .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .memwrite(memwrite), .adr(adr), .writedata(writedata),
        .busy(busy_s), .done(done_s), .pass(pass_s), .fail_code(code_s),
        .match_cnt(m_s), .exp_cnt(e_s), .cycles(cyc_s), .ovf(ovf_s),
        .dbg_state(dbg_s)
    );

    mem_write_checker #(.WIDTH(W), .DEPTH(4), .TIMEOUT(20), .CYC_W(CW), .STRICT(0)) u_l (
        .clk(clk), .reset(reset), .clear(clear), .exp_wr(exp_wr),
        .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .memwrite(memwrite), .adr(adr), .writedata(writedata),
        .busy(busy_l), .done(done_l), .pass(pass_l), .fail_code(code_l),
        .match_cnt(m_l), .exp_cnt(e_l), .cycles(cyc_l), .ovf(ovf_l),
        .dbg_state(dbg_l)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          clr, wr;
        logic [W-1:0]  ea, ed;
        logic          st, mw;
        logic [W-1:0]  a, d;
        logic          busy, done, pass;
        logic [1:0]    code;
        logic [2:0]    m, e;
        logic [CW-1:0] cyc;
        logic          ovf;
    } vec_t;

    vec_t vecs [40];
    int   nv;

    task automatic add(input logic clr, input logic wr, input logic [W-1:0] ea, input logic [W-1:0] ed,
                       input logic st, input logic mw, input logic [W-1:0] a, input logic [W-1:0] d,
                       input logic b, input logic dn, input logic p, input logic [1:0] c,
                       input logic [2:0] m, input logic [2:0] e, input logic [CW-1:0] cyc, input logic ov);
        vecs[nv] = '{clr, wr, ea, ed, st, mw, a, d, b, dn, p, c, m, e, cyc, ov};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply one edge worth of inputs off-edge, then sample just after the edge.
    task automatic step(input logic clr, input logic wr, input logic [W-1:0] ea, input logic [W-1:0] ed,
                        input logic st, input logic mw, input logic [W-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        clear = clr; exp_wr = wr; exp_addr = ea; exp_data = ed;
        start = st; memwrite = mw; adr = a; writedata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_s(input string tag, input logic b, input logic dn, input logic p,
                           input logic [1:0] c, input logic [2:0] m, input logic [2:0] e,
                           input logic [CW-1:0] cyc, input logic ov);
        chk({tag, " busy"}, 32'(busy_s), 32'(b));
        chk({tag, " done"}, 32'(done_s), 32'(dn));
        chk({tag, " pass"}, 32'(pass_s), 32'(p));
        chk({tag, " fail_code"}, 32'(code_s), 32'(c));
        chk({tag, " match_cnt"}, 32'(m_s), 32'(m));
        chk({tag, " exp_cnt"}, 32'(e_s), 32'(e));
        chk({tag, " cycles"}, 32'(cyc_s), 32'(cyc));
        chk({tag, " ovf"}, 32'(ovf_s), 32'(ov));
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        nv       = 0;
        reset = 1'b0;
        clear = 0; exp_wr = 0; exp_addr = 0; exp_data = 0;
        start = 0; memwrite = 0; adr = 0; writedata = 0;

        //   clr wr ea  ed st mw a   d    busy done pass code m e cyc ovf
        add(0, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0); // 0 reset state
        add(0, 1, 80, 7, 0, 0, 0,  0,   0, 0, 0, 0, 0, 1, 0, 0); // 1 load (80,7)
        add(0, 0, 0,  0, 1, 0, 0,  0,   1, 0, 0, 0, 0, 1, 0, 0); // 2 start
        add(0, 0, 0,  0, 0, 0, 0,  0,   1, 0, 0, 0, 0, 1, 1, 0); // 3
        add(0, 0, 0,  0, 0, 0, 0,  0,   1, 0, 0, 0, 0, 1, 2, 0); // 4
        add(0, 0, 0,  0, 0, 0, 0,  0,   1, 0, 0, 0, 0, 1, 3, 0); // 5
        add(0, 0, 0,  0, 0, 0, 0,  0,   1, 0, 0, 0, 0, 1, 4, 0); // 6
        add(0, 0, 0,  0, 0, 1, 80, 7,   0, 1, 1, 0, 1, 1, 5, 0); // 7 80<-7 passes
        add(0, 0, 0,  0, 0, 0, 0,  0,   0, 1, 1, 0, 1, 1, 5, 0); // 8 PASS holds
        add(1, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0); // 9 clear
        add(0, 1, 80, 7, 0, 0, 0,  0,   0, 0, 0, 0, 0, 1, 0, 0); // 10
        add(0, 1, 84, 9, 0, 0, 0,  0,   0, 0, 0, 0, 0, 2, 0, 0); // 11
        add(0, 0, 0,  0, 1, 0, 0,  0,   1, 0, 0, 0, 0, 2, 0, 0); // 12 start
        add(0, 0, 0,  0, 0, 1, 80, 7,   1, 0, 0, 0, 1, 2, 1, 0); // 13 first match
        add(0, 0, 0,  0, 0, 1, 84, 5,   0, 1, 0, 2, 1, 2, 2, 0); // 14 data mismatch
        add(1, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0); // 15 clear
        add(0, 1, 80, 7, 1, 0, 0,  0,   1, 0, 0, 0, 0, 1, 0, 0); // 16 push+start together
        add(0, 0, 0,  0, 0, 1, 76, 3,   0, 1, 0, 1, 0, 1, 1, 0); // 17 addr mismatch
        add(1, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0); // 18 clear
        add(0, 1, 1,  1, 0, 0, 0,  0,   0, 0, 0, 0, 0, 1, 0, 0); // 19
        add(0, 1, 2,  2, 0, 0, 0,  0,   0, 0, 0, 0, 0, 2, 0, 0); // 20
        add(0, 1, 3,  3, 0, 0, 0,  0,   0, 0, 0, 0, 0, 3, 0, 0); // 21
        add(0, 1, 4,  4, 0, 0, 0,  0,   0, 0, 0, 0, 0, 4, 0, 0); // 22 full
        add(0, 1, 5,  5, 0, 0, 0,  0,   0, 0, 0, 0, 0, 4, 0, 1); // 23 overflow
        add(1, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0); // 24 clear
        add(0, 0, 0,  0, 1, 0, 0,  0,   0, 1, 1, 0, 0, 0, 0, 0); // 25 empty start passes
        add(1, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0); // 26 clear
        add(0, 1, 80, 7, 1, 0, 0,  0,   1, 0, 0, 0, 0, 1, 0, 0); // 27
        add(0, 1, 90, 1, 1, 0, 0,  0,   1, 0, 0, 0, 0, 1, 1, 0); // 28 push/start ignored in RUN
        add(0, 0, 0,  0, 0, 1, 80, 7,   0, 1, 1, 0, 1, 1, 2, 0); // 29
        add(0, 0, 0,  0, 1, 0, 0,  0,   1, 0, 0, 0, 0, 1, 0, 0); // 30 re-run, table kept
        add(0, 0, 0,  0, 0, 1, 80, 7,   0, 1, 1, 0, 1, 1, 1, 0); // 31
        add(1, 1, 5,  5, 1, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0); // 32 clear wins

        // Reset: hold low for two edges, release off-edge.
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        for (int i = 0; i < nv; i++) begin
            step(vecs[i].clr, vecs[i].wr, vecs[i].ea, vecs[i].ed,
                 vecs[i].st, vecs[i].mw, vecs[i].a, vecs[i].d);
            check_s($sformatf("v%0d", i), vecs[i].busy, vecs[i].done, vecs[i].pass,
                    vecs[i].code, vecs[i].m, vecs[i].e, vecs[i].cyc, vecs[i].ovf);
        end

        // STRICT=0 ignores a stray address; STRICT=1 fails on it.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 80, 7, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 76, 3);
        chk("strict stray fail_code", 32'(code_s), 32'd1);
        chk("loose stray busy", 32'(busy_l), 32'd1);
        chk("loose stray done", 32'(done_l), 32'd0);
        step(0, 0, 0, 0, 0, 1, 80, 7);
        chk("loose later pass", 32'(pass_l), 32'd1);
        chk("loose later match_cnt", 32'(m_l), 32'd1);
        chk("loose later fail_code", 32'(code_l), 32'd0);

        // Timeout with no writes: done exactly 20 edges after busy rose.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 80, 7, 1, 0, 0, 0);
        chk("tmo busy rise", 32'(busy_s), 32'd1);
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            idle();
            if (done_s) n = k;
        end
        chk("tmo latency", 32'(n), 32'd20);
        chk("tmo fail_code", 32'(code_s), 32'd3);
        chk("tmo cycles", 32'(cyc_s), 32'd20);
        chk("tmo pass", 32'(pass_s), 32'd0);

        // Matching write on the timeout edge wins.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 80, 7, 1, 0, 0, 0);
        repeat (19) idle();
        chk("edge pre done", 32'(done_s), 32'd0);
        step(0, 0, 0, 0, 0, 1, 80, 7);
        check_s("edge match", 0, 1, 1, 0, 1, 1, 20, 0);

        // Mismatching data on the timeout edge reports its own code.
        step(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (19) idle();
        step(0, 0, 0, 0, 0, 1, 80, 8);
        chk("edge data fail_code", 32'(code_s), 32'd2);
        chk("edge data done", 32'(done_s), 32'd1);

        // Asynchronous reset mid-RUN.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 80, 7, 0, 0, 0, 0);
        step(0, 1, 84, 9, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 80, 7);
        chk("pre-reset match_cnt", 32'(m_s), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst busy", 32'(busy_s), 32'd0);
        chk("rst match_cnt", 32'(m_s), 32'd0);
        chk("rst exp_cnt", 32'(e_s), 32'd0);
        chk("rst cycles", 32'(cyc_s), 32'd0);
        #2 reset = 1'b1;
        idle();
        chk("post-rst state", 32'(dbg_s), 32'd0);
        check_s("post-rst", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check_s("post-rst empty start", 0, 1, 1, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
